atm_acct_ctrl: RTL
==================

ATM_ACCT_CTRL -- requirements
Module: atm_acct_ctrl

Interface
REQ-001 SHALL have parameter AMT_W, 8, amount/balance width in bits.
REQ-002 SHALL have parameter NUM_ACCT, 4, number of accounts (>=2); ACCT_W = clog2(NUM_ACCT).
REQ-003 SHALL have parameter MAX_TRIES, 3, wrong-PIN attempts before account lockout.
REQ-004 SHALL have parameter TIMEOUT, 15, idle cycles before forced card eject.
REQ-005 SHALL have parameter CORRECT_PIN, 4'b0110, PIN for all accounts.
REQ-006 Ports: clk in 1 clock; rst in 1 reset; one clock; reset is asynchronous and active-high.
REQ-007 Ports: card_in in 1 card-present level; acct_id in ACCT_W account on card; lang_valid in 1 language chosen; pin_valid in 1 PIN strobe; pin in 4 PIN; op_valid in 1 op strobe; op in 2 (00 deposit, 01 balance, 10 withdraw, 11 exit); amount in AMT_W; confirm in 1; cancel in 1; again in 1.
REQ-008 Ports: incorrect_pin out 1; locked out 1; no_balance out 1; overflow out 1; success out 1; eject out 1 (all single-cycle pulses); balance out AMT_W balance of current account; busy out 1 (state != IDLE).

Function
REQ-009 States SHALL be IDLE, LANG, PIN, MENU, AMOUNT, CONFIRM, SHOW, MORE; all outputs registered, one-cycle latency from input to pulse.
REQ-010 IDLE: card_in=1 latches acct_id; if account locked -> pulse locked and eject, stay IDLE; else -> LANG.
REQ-011 LANG -> PIN on lang_valid.
REQ-012 PIN on pin_valid: match -> MENU, clear try counter of account; mismatch -> pulse incorrect_pin, increment counter; counter reaching MAX_TRIES -> set lock bit, pulse locked and eject, -> IDLE; else stay PIN.
REQ-013 MENU on op_valid: 00/10 -> AMOUNT latching op; 01 -> SHOW; 11 -> pulse eject, -> IDLE.
REQ-014 AMOUNT: amount==0 holds; nonzero -> CONFIRM latching amount.
REQ-015 CONFIRM on confirm: deposit adds; sum exceeding 2^AMT_W-1 -> pulse overflow, balance unchanged; withdraw with amount>balance -> pulse no_balance, unchanged; amount==balance allowed (result 0); legal update -> pulse success; all cases -> MORE.
REQ-016 SHOW: balance presented; confirm -> MORE.
REQ-017 MORE: again=1 -> MENU; else pulse eject, -> IDLE.
REQ-018 cancel in any non-IDLE state SHALL pulse eject, discard latched amount, -> IDLE next cycle; cancel has priority over every other input.
REQ-019 Inactivity counter SHALL reset on any strobe (lang_valid, pin_valid, op_valid, confirm, cancel) and in IDLE; reaching TIMEOUT -> pulse eject, -> IDLE, no balance change.
REQ-020 card_in falling in any non-IDLE state SHALL be treated as cancel.
REQ-021 Per-account balances SHALL be stored in an NUM_ACCT x AMT_W register array; only the latched account is modified.
REQ-022 Lock bits and try counters SHALL be per account; lock cleared only by rst.
REQ-023 Simultaneous cancel and confirm in CONFIRM: cancel wins, no balance change.

Reset
REQ-024 rst SHALL force IDLE, all balances 0, all try counters 0, all lock bits 0, inactivity counter 0, all pulse outputs 0, balance output 0.
REQ-025 rst asserted mid-transaction SHALL abandon it with no partial balance update.

Structure
REQ-026 State encoding enum and op codes (OP_DEP, OP_BAL, OP_WDR, OP_EXIT) SHALL live in shared package atm_pkg.
REQ-027 One sub-module atm_timeout_cnt (parameter TIMEOUT; inputs clk, rst, clear, enable; output expired) SHALL implement REQ-019.

Verification
REQ-028 Acct 1, PIN 0110, deposit 20, confirm -> success pulse, balance 20; withdraw 20 -> success, balance 0.
REQ-029 Acct 2 balance 0, withdraw 5, confirm -> no_balance pulse, balance 0, state MORE.
REQ-030 AMT_W=8, balance 250, deposit 10 -> overflow pulse, balance 250.
REQ-031 Acct 3, three wrong PINs -> incorrect_pin x3, locked+eject on third; reinsert acct 3 -> immediate locked+eject; acct 0 unaffected.
REQ-032 Enter MENU then no strobes for 15 cycles -> eject pulse, IDLE, busy=0.
REQ-033 In CONFIRM assert cancel and confirm same cycle -> eject, no balance change; rst mid-AMOUNT -> all balances 0.

Source files
------------

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state encoding and op codes for the ATM account controller
package atm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LANG,
    S_PIN,
    S_MENU,
    S_AMOUNT,
    S_CONFIRM,
    S_SHOW,
    S_MORE
  } state_e;

  localparam logic [1:0] OP_DEP  = 2'b00;
  localparam logic [1:0] OP_BAL  = 2'b01;
  localparam logic [1:0] OP_WDR  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  function automatic logic needs_amount(input logic [1:0] op);
    return (op == OP_DEP) || (op == OP_WDR);
  endfunction

endpackage

// File: rtl/atm_timeout_cnt.sv
// rtl/atm_timeout_cnt.sv - inactivity counter; flags the cycle on which TIMEOUT idle cycles have elapsed
module atm_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // expired is raised on the edge that would complete the TIMEOUT-th idle cycle
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      expired = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/atm_acct_ctrl.sv
// rtl/atm_acct_ctrl.sv - ATM session FSM with per-account balances, PIN lockout and inactivity eject
module atm_acct_ctrl
  import atm_pkg::*;
#(
  parameter int         AMT_W       = 8,
  parameter int         NUM_ACCT    = 4,
  parameter int         MAX_TRIES   = 3,
  parameter int         TIMEOUT     = 15,
  parameter logic [3:0] CORRECT_PIN = 4'b0110
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        card_in,
  input  logic [$clog2(NUM_ACCT)-1:0] acct_id,
  input  logic                        lang_valid,
  input  logic                        pin_valid,
  input  logic [3:0]                  pin,
  input  logic                        op_valid,
  input  logic [1:0]                  op,
  input  logic [AMT_W-1:0]            amount,
  input  logic                        confirm,
  input  logic                        cancel,
  input  logic                        again,
  output logic                        incorrect_pin,
  output logic                        locked,
  output logic                        no_balance,
  output logic                        overflow,
  output logic                        success,
  output logic                        eject,
  output logic [AMT_W-1:0]            balance,
  output logic                        busy
);

  localparam int ACCT_W = $clog2(NUM_ACCT);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_e state_q, state_d;

  logic [AMT_W-1:0]    bal_q   [NUM_ACCT];
  logic [AMT_W-1:0]    bal_d   [NUM_ACCT];
  logic [TRY_W-1:0]    tries_q [NUM_ACCT];
  logic [TRY_W-1:0]    tries_d [NUM_ACCT];
  logic [NUM_ACCT-1:0] lock_q, lock_d;
  logic [ACCT_W-1:0]   acct_q, acct_d;
  logic [1:0]          op_q, op_d;
  logic [AMT_W-1:0]    amt_q, amt_d;
  logic [AMT_W-1:0]    balance_q, balance_d;
  logic incorrect_pin_q, incorrect_pin_d;
  logic locked_q, locked_d;
  logic no_balance_q, no_balance_d;
  logic overflow_q, overflow_d;
  logic success_q, success_d;
  logic eject_q, eject_d;

  logic             busy_w;
  logic             strobe;
  logic             abort;
  logic             tmo_exp;
  logic             kill;
  logic             pin_ok;
  logic             last_try;
  logic             dep_ovf;
  logic             wdr_short;
  logic [AMT_W-1:0] cur_bal;
  logic [AMT_W:0]   dep_sum;

  assign busy_w    = (state_q != S_IDLE);
  assign strobe    = lang_valid | pin_valid | op_valid | confirm | cancel;
  // a pulled card is handled exactly like cancel
  assign abort     = busy_w & (cancel | ~card_in);
  assign kill      = abort | tmo_exp;
  assign pin_ok    = (pin == CORRECT_PIN);
  assign last_try  = (tries_q[acct_q] == LAST_TRY);
  assign cur_bal   = bal_q[acct_q];
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, amt_q};
  assign dep_ovf   = dep_sum[AMT_W];
  assign wdr_short = (amt_q > cur_bal);

  atm_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (strobe | ~busy_w),
    .enable (busy_w),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (card_in && !lock_q[acct_id]) state_d = S_LANG;
        S_LANG:    if (lang_valid) state_d = S_PIN;
        S_PIN: begin
          if (pin_valid) begin
            if (pin_ok)        state_d = S_MENU;
            else if (last_try) state_d = S_IDLE;
          end
        end
        S_MENU: begin
          if (op_valid) begin
            if (needs_amount(op)) state_d = S_AMOUNT;
            else if (op == OP_BAL) state_d = S_SHOW;
            else                   state_d = S_IDLE;
          end
        end
        S_AMOUNT:  if (amount != '0) state_d = S_CONFIRM;
        S_CONFIRM: if (confirm) state_d = S_MORE;
        S_SHOW:    if (confirm) state_d = S_MORE;
        S_MORE:    state_d = again ? S_MENU : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bal_d           = bal_q;
    tries_d         = tries_q;
    lock_d          = lock_q;
    acct_d          = acct_q;
    op_d            = op_q;
    amt_d           = amt_q;
    incorrect_pin_d = 1'b0;
    locked_d        = 1'b0;
    no_balance_d    = 1'b0;
    overflow_d      = 1'b0;
    success_d       = 1'b0;
    eject_d         = 1'b0;
    if (kill) begin
      eject_d = 1'b1;
      amt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (card_in) begin
            acct_d = acct_id;
            if (lock_q[acct_id]) begin
              locked_d = 1'b1;
              eject_d  = 1'b1;
            end
          end
        end
        S_PIN: begin
          if (pin_valid) begin
            if (pin_ok) begin
              tries_d[acct_q] = '0;
            end else begin
              incorrect_pin_d = 1'b1;
              tries_d[acct_q] = tries_q[acct_q] + TRY_W'(1);
              if (last_try) begin
                lock_d[acct_q] = 1'b1;
                locked_d       = 1'b1;
                eject_d        = 1'b1;
              end
            end
          end
        end
        S_MENU: begin
          if (op_valid) begin
            if (needs_amount(op)) op_d = op;
            if (op == OP_EXIT)    eject_d = 1'b1;
          end
        end
        S_AMOUNT: begin
          if (amount != '0) amt_d = amount;
        end
        S_CONFIRM: begin
          if (confirm) begin
            if (op_q == OP_DEP) begin
              if (dep_ovf) begin
                overflow_d = 1'b1;
              end else begin
                bal_d[acct_q] = dep_sum[AMT_W-1:0];
                success_d     = 1'b1;
              end
            end else if (wdr_short) begin
              no_balance_d = 1'b1;
            end else begin
              bal_d[acct_q] = cur_bal - amt_q;
              success_d     = 1'b1;
            end
          end
        end
        S_MORE: begin
          if (!again) eject_d = 1'b1;
        end
        default: ;
      endcase
    end
    balance_d = bal_d[acct_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCT; i++) begin
        bal_q[i]   <= '0;
        tries_q[i] <= '0;
      end
      lock_q          <= '0;
      acct_q          <= '0;
      op_q            <= OP_DEP;
      amt_q           <= '0;
      balance_q       <= '0;
      incorrect_pin_q <= 1'b0;
      locked_q        <= 1'b0;
      no_balance_q    <= 1'b0;
      overflow_q      <= 1'b0;
      success_q       <= 1'b0;
      eject_q         <= 1'b0;
    end else begin
      bal_q           <= bal_d;
      tries_q         <= tries_d;
      lock_q          <= lock_d;
      acct_q          <= acct_d;
      op_q            <= op_d;
      amt_q           <= amt_d;
      balance_q       <= balance_d;
      incorrect_pin_q <= incorrect_pin_d;
      locked_q        <= locked_d;
      no_balance_q    <= no_balance_d;
      overflow_q      <= overflow_d;
      success_q       <= success_d;
      eject_q         <= eject_d;
    end
  end

  assign incorrect_pin = incorrect_pin_q;
  assign locked        = locked_q;
  assign no_balance    = no_balance_q;
  assign overflow      = overflow_q;
  assign success       = success_q;
  assign eject         = eject_q;
  assign balance       = balance_q;
  assign busy          = busy_w;

endmodule
